// File: rtl/text_map_writer.sv
// Character-map writer: accepts an ASCII stream, tracks a cursor and writes the 80x60 text map.
// Optional macro WRAP_CLEAR_EN: blank each new row on every row advance.
module text_map_writer #(
   parameter int         COLS       = 80,
   parameter int         ROWS       = 60,
   parameter logic [7:0] BLANK_CHAR = 8'h20
) (
   input  logic        CLK_50M,
   input  logic        RST_N,
   input  logic [7:0]  CHAR_IN,
   input  logic        CHAR_VALID,
   output logic        CHAR_READY,
   output logic        MAP_WE,
   output logic [12:0] MAP_ADDR,
   output logic [7:0]  MAP_DIN,
   output logic [6:0]  CUR_COL,
   output logic [5:0]  CUR_ROW,
   output logic        BUSY
);

   localparam logic [1:0] S_CLEAR_ALL  = 2'd0;
   localparam logic [1:0] S_IDLE       = 2'd1;
   localparam logic [1:0] S_WRITE      = 2'd2;
`ifdef WRAP_CLEAR_EN
   localparam logic [1:0] S_CLEAR_LINE = 2'd3;
`endif
   localparam logic [6:0] LAST_COL     = 7'(COLS - 1);
   localparam logic [5:0] LAST_ROW     = 6'(ROWS - 1);

   logic [1:0]  r_state, w_state_n;
   logic [6:0]  r_col, w_col_n;
   logic [5:0]  r_row, w_row_n;
   logic [6:0]  r_clr_col, w_clr_col_n;
   logic [5:0]  r_clr_row, w_clr_row_n;
   logic        r_adv, w_adv_n;
   logic        r_we, w_we_n;
   logic [12:0] r_addr, w_addr_n;
   logic [7:0]  r_din, w_din_n;
   logic        r_ready, r_busy;
   logic [5:0]  w_row_inc;
   logic [6:0]  w_col_dec;

   assign w_row_inc = (r_row == LAST_ROW) ? 6'd0 : r_row + 6'd1;
   assign w_col_dec = r_col - 7'd1;

   // Next-state, cursor and write-port computation.
   always_comb begin
      w_state_n   = r_state;
      w_col_n     = r_col;
      w_row_n     = r_row;
      w_clr_col_n = r_clr_col;
      w_clr_row_n = r_clr_row;
      w_adv_n     = 1'b0;
      w_we_n      = 1'b0;
      w_addr_n    = r_addr;
      w_din_n     = r_din;
      case (r_state)
         S_CLEAR_ALL: begin
            w_we_n   = 1'b1;
            w_addr_n = {r_clr_row, r_clr_col};
            w_din_n  = BLANK_CHAR;
            if (r_clr_col == LAST_COL) begin
               w_clr_col_n = 7'd0;
               if (r_clr_row == LAST_ROW) begin
                  w_clr_row_n = 6'd0;
                  w_state_n   = S_IDLE;
               end else begin
                  w_clr_row_n = r_clr_row + 6'd1;
               end
            end else begin
               w_clr_col_n = r_clr_col + 7'd1;
            end
         end
`ifdef WRAP_CLEAR_EN
         S_CLEAR_LINE: begin
            w_we_n   = 1'b1;
            w_addr_n = {r_row, r_clr_col};
            w_din_n  = BLANK_CHAR;
            if (r_clr_col == LAST_COL) begin
               w_clr_col_n = 7'd0;
               w_state_n   = S_IDLE;
            end else begin
               w_clr_col_n = r_clr_col + 7'd1;
            end
         end
`endif
         S_IDLE: begin
            if (CHAR_VALID && r_ready) begin
               case (CHAR_IN)
                  8'h0D: begin
                     w_col_n   = 7'd0;
                     w_state_n = S_WRITE;
                  end
                  8'h0A: begin
                     w_col_n   = 7'd0;
                     w_row_n   = w_row_inc;
`ifdef WRAP_CLEAR_EN
                     w_clr_col_n = 7'd0;
                     w_state_n   = S_CLEAR_LINE;
`else
                     w_state_n   = S_WRITE;
`endif
                  end
                  8'h08: begin
                     w_state_n = S_WRITE;
                     if (r_col != 7'd0) begin
                        w_col_n  = w_col_dec;
                        w_we_n   = 1'b1;
                        w_addr_n = {r_row, w_col_dec};
                        w_din_n  = BLANK_CHAR;
                     end else begin
                        w_col_n  = r_col;
                     end
                  end
                  8'h0C: begin
                     w_col_n     = 7'd0;
                     w_row_n     = 6'd0;
                     w_clr_col_n = 7'd0;
                     w_clr_row_n = 6'd0;
                     w_state_n   = S_CLEAR_ALL;
                  end
                  default: begin
                     w_we_n    = 1'b1;
                     w_addr_n  = {r_row, r_col};
                     w_din_n   = CHAR_IN;
                     w_adv_n   = 1'b1;
                     w_state_n = S_WRITE;
                  end
               endcase
            end else begin
               w_state_n = S_IDLE;
            end
         end
         S_WRITE: begin
            w_state_n = S_IDLE;
            // Cursor advance is deferred to the end of the write cycle.
            if (r_adv) begin
               if (r_col == LAST_COL) begin
                  w_col_n = 7'd0;
                  w_row_n = w_row_inc;
`ifdef WRAP_CLEAR_EN
                  w_clr_col_n = 7'd0;
                  w_state_n   = S_CLEAR_LINE;
`endif
               end else begin
                  w_col_n = r_col + 7'd1;
               end
            end else begin
               w_col_n = r_col;
            end
         end
         default: begin
            w_col_n     = 7'd0;
            w_row_n     = 6'd0;
            w_clr_col_n = 7'd0;
            w_clr_row_n = 6'd0;
            w_state_n   = S_CLEAR_ALL;
         end
      endcase
   end

   // State and registered outputs; reset forces a fresh full clear.
   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         r_state   <= S_CLEAR_ALL;
         r_col     <= 7'd0;
         r_row     <= 6'd0;
         r_clr_col <= 7'd0;
         r_clr_row <= 6'd0;
         r_adv     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 13'd0;
         r_din     <= 8'd0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b1;
      end else begin
         r_state   <= w_state_n;
         r_col     <= w_col_n;
         r_row     <= w_row_n;
         r_clr_col <= w_clr_col_n;
         r_clr_row <= w_clr_row_n;
         r_adv     <= w_adv_n;
         r_we      <= w_we_n;
         r_addr    <= w_addr_n;
         r_din     <= w_din_n;
         r_ready   <= (w_state_n == S_IDLE);
`ifdef WRAP_CLEAR_EN
         r_busy    <= (w_state_n == S_CLEAR_ALL) || (w_state_n == S_CLEAR_LINE);
`else
         r_busy    <= (w_state_n == S_CLEAR_ALL);
`endif
      end
   end

   assign CHAR_READY = r_ready;
   assign MAP_WE     = r_we;
   assign MAP_ADDR   = r_addr;
   assign MAP_DIN    = r_din;
   assign CUR_COL    = r_col;
   assign CUR_ROW    = r_row;
   assign BUSY       = r_busy;

endmodule

// File: tb/tb_text_map_writer.sv
// Scoreboard bench for text_map_writer: expected map writes are queued by the stimulus
// and consumed by a negedge monitor; cursor/handshake values are checked directly.
module tb_text_map_writer;

   logic        clk = 1'b0;
   logic        RST_N;
   logic [7:0]  CHAR_IN;
   logic        CHAR_VALID;
   logic        CHAR_READY;
   logic        MAP_WE;
   logic [12:0] MAP_ADDR;
   logic [7:0]  MAP_DIN;
   logic [6:0]  CUR_COL;
   logic [5:0]  CUR_ROW;
   logic        BUSY;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_seen = 0;
   logic [20:0] exp_q[$];

   text_map_writer dut (
      .CLK_50M(clk), .RST_N(RST_N), .CHAR_IN(CHAR_IN), .CHAR_VALID(CHAR_VALID),
      .CHAR_READY(CHAR_READY), .MAP_WE(MAP_WE), .MAP_ADDR(MAP_ADDR), .MAP_DIN(MAP_DIN),
      .CUR_COL(CUR_COL), .CUR_ROW(CUR_ROW), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   // Monitor: every map write must match the head of the expected queue.
   always @(negedge clk) begin
      logic [20:0] e;
      if (MAP_WE === 1'b1) begin
         wr_seen++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr=%h din=%h, required no write", MAP_ADDR, MAP_DIN);
         end else begin
            e = exp_q.pop_front();
            if ({MAP_ADDR, MAP_DIN} !== e) begin
               n_bad++;
               $display("FAIL map_write: got addr=%h din=%h, required addr=%h din=%h",
                        MAP_ADDR, MAP_DIN, e[20:8], e[7:0]);
            end
         end
         if (MAP_ADDR[6:0] > 7'd79) begin
            n_bad++;
            $display("FAIL col_range: got col=%0d, required <=79", MAP_ADDR[6:0]);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input int row, input int col, input logic [7:0] d);
      logic [5:0] r;
      logic [6:0] c;
      r = 6'(row);
      c = 7'(col);
      exp_q.push_back({r, c, d});
   endtask

   task automatic push_row_blank(input int row);
      for (int c = 0; c < 80; c++) push(row, c, 8'h20);
   endtask

   task automatic push_full_clear();
      for (int r = 0; r < 60; r++) push_row_blank(r);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (CHAR_READY !== 1'b1 && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout: got CHAR_READY=%b, required 1", CHAR_READY);
      end
      @(negedge clk); #1;
   endtask

   task automatic send(input logic [7:0] c, input logic exp_we);
      int n;
      n = 0;
      CHAR_IN    = c;
      CHAR_VALID = 1'b1;
      while (CHAR_READY !== 1'b1 && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got CHAR_READY=%b, required 1", CHAR_READY);
         CHAR_VALID = 1'b0;
         return;
      end
      @(posedge clk); #1;
      CHAR_VALID = 1'b0;
      check("ready_low_after_accept", 64'(CHAR_READY), 64'd0);
      check("we_after_accept", 64'(MAP_WE), 64'(exp_we));
   endtask

   task automatic check_cursor(input string name, input int row, input int col);
      check(name, {52'd0, CUR_ROW, CUR_COL}, {52'd0, 6'(row), 7'(col)});
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {27'd0, MAP_WE, MAP_ADDR, MAP_DIN, CUR_COL, CUR_ROW, CHAR_READY, BUSY}, 64'd1);
   endtask

   task automatic send_lf(input int new_row);
`ifdef WRAP_CLEAR_EN
      push_row_blank(new_row);
`endif
      send(8'h0A, 1'b0);
   endtask

   task automatic send_print(input int row, input int col, input logic [7:0] c);
      push(row, col, c);
`ifdef WRAP_CLEAR_EN
      if (col == 79) push_row_blank((row == 59) ? 0 : row + 1);
`endif
      send(c, 1'b1);
   endtask

   initial begin
      int base;
      int n;
      RST_N      = 1'b0;
      CHAR_IN    = 8'h00;
      CHAR_VALID = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_values");

      // Full clear after reset release.
      push_full_clear();
      RST_N = 1'b1;
      wait_idle();
      check("clear_all_drained", 64'(exp_q.size()), 64'd0);
      check("clear_all_count", 64'(wr_seen), 64'd4800);
      check("ready_after_clear", {62'd0, CHAR_READY, BUSY}, 64'd2);
      check_cursor("cursor_after_clear", 0, 0);

      // Single printable at home.
      send_print(0, 0, 8'h41);
      wait_idle();
      check_cursor("cursor_after_A", 0, 1);

      send(8'h0D, 1'b0);
      wait_idle();
      check_cursor("cursor_after_CR", 0, 0);

      // 81 printables from home: wraps to row 1.
      for (int k = 0; k < 81; k++) send_print((k < 80) ? 0 : 1, k % 80, 8'(8'h30 + 8'(k % 40)));
      wait_idle();
      check_cursor("cursor_after_81", 1, 1);

      // BS at column 0 does nothing.
      send(8'h0D, 1'b0);
      wait_idle();
      send(8'h08, 1'b0);
      wait_idle();
      check_cursor("cursor_after_BS_col0", 1, 0);

      // BS at (2,5) blanks (2,4).
      send_lf(2);
      for (int k = 0; k < 5; k++) send_print(2, k, 8'h61 + 8'(k));
      wait_idle();
      check_cursor("cursor_at_2_5", 2, 5);
      push(2, 4, 8'h20);
      send(8'h08, 1'b1);
      wait_idle();
      check_cursor("cursor_after_BS", 2, 4);

      // LF from (59,10) wraps to (0,0).
      for (int r = 3; r <= 59; r++) send_lf(r);
      send(8'h0D, 1'b0);
      for (int k = 0; k < 10; k++) send_print(59, k, 8'h4B);
      wait_idle();
      check_cursor("cursor_at_59_10", 59, 10);
      send_lf(0);
      wait_idle();
      check_cursor("cursor_after_LF_wrap", 0, 0);

      // Printable at the final cell then cursor home.
      for (int r = 1; r <= 59; r++) send_lf(r);
      for (int k = 0; k < 79; k++) send_print(59, k, 8'h2E);
      wait_idle();
      check_cursor("cursor_at_59_79", 59, 79);
      send_print(59, 79, 8'h5A);
      wait_idle();
      check_cursor("cursor_after_last_cell", 0, 0);
      check("queue_drained_mid", 64'(exp_q.size()), 64'd0);

      // FF starts a clear; reset partway through restarts it from zero.
      send(8'h0D, 1'b0);
      send_print(0, 0, 8'h51);
      wait_idle();
      push_full_clear();
      send(8'h0C, 1'b0);
      check("busy_after_FF", 64'(BUSY), 64'd1);
      base = wr_seen;
      n = 0;
      while (wr_seen < base + 2000 && n < 10000) begin
         @(negedge clk); #2;
         n++;
      end
      check("ff_clear_progress", 64'(wr_seen - base), 64'd2000);
      #1;
      RST_N = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_values_mid_clear");
      push_full_clear();
      base = wr_seen;
      RST_N = 1'b1;
      wait_idle();
      check("restart_clear_count", 64'(wr_seen - base), 64'd4800);
      check("queue_drained_end", 64'(exp_q.size()), 64'd0);
      check("ready_after_restart", {62'd0, CHAR_READY, BUSY}, 64'd2);
      check_cursor("cursor_after_restart", 0, 0);

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
